// File: rtl/z80_busreq_handshake.sv
// Z80 BUSREQ/BUSACK responder: turns the Nios bus request into a Z80 bus handshake,
// drives bus_grant to the loader mux, and exposes status/counters/irq over Avalon-MM.
module z80_busreq_handshake #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req_n,
  input  logic        z80_busack_n,
  output logic        z80_busreq_n,
  output logic        bus_grant,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANTED = 3'd2,
    RELEASE = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]      timer_q, timer_d;
  logic [CNT_W-1:0]   grant_cnt_q, grant_cnt_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic               lost_flag_q, lost_flag_d;
  logic [1:0]         irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
  logic               busreq_n_q, busreq_n_d;
  logic               grant_q, grant_d;

  logic ack_s, set_to, set_lost, inc_cnt, wr_en, wr_clr;
  logic unused_wd;

  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect && !write_n && (address == 2'd2);
  assign wr_clr    = chipselect && !write_n && (address == 2'd3);
  assign unused_wd = ^writedata[30:3];

  // BUSACK_n is asynchronous; idles high (not acknowledged) out of reset
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], z80_busack_n};
  end

  always_comb begin
    state_d  = state_q;
    set_to   = 1'b0;
    set_lost = 1'b0;
    inc_cnt  = 1'b0;
    case (state_q)
      IDLE:    if (!bus_req_n) state_d = REQ;
      REQ: begin
        if (!ack_s) begin
          state_d = GRANTED;
          inc_cnt = 1'b1;
        end else if (bus_req_n) begin
          state_d = RELEASE;
        end else if (timer_q == T_LAST) begin
          state_d = TIMEOUT;
          set_to  = 1'b1;
        end
      end
      GRANTED: begin
        if (bus_req_n) begin
          state_d = RELEASE;
        end else if (ack_s) begin
          state_d  = REQ;
          set_lost = 1'b1;
        end
      end
      RELEASE: if (ack_s) state_d = IDLE;
      TIMEOUT: if (bus_req_n && ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer counts cycles spent continuously in REQ; any entry into REQ restarts it
  always_comb begin
    timer_d = '0;
    if (state_q == REQ && state_d == REQ) timer_d = timer_q + 1'b1;
  end

  // Set events beat a same-cycle write-1-to-clear
  always_comb begin
    timeout_flag_d = set_to   | (timeout_flag_q & ~(wr_clr & writedata[1]));
    lost_flag_d    = set_lost | (lost_flag_q    & ~(wr_clr & writedata[2]));
    grant_cnt_d    = (wr_clr && writedata[31]) ? '0 : grant_cnt_q;
    if (inc_cnt) grant_cnt_d = grant_cnt_d + 1'b1;
    irq_en_d       = wr_en ? writedata[1:0] : irq_en_q;
    irq_d          = |({lost_flag_q, timeout_flag_q} & irq_en_q);
    busreq_n_d     = !(state_d == REQ || state_d == GRANTED);
    grant_d        = (state_d == GRANTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      grant_cnt_q    <= '0;
      timeout_flag_q <= 1'b0;
      lost_flag_q    <= 1'b0;
      irq_en_q       <= 2'b00;
      irq_q          <= 1'b0;
      busreq_n_q     <= 1'b1;
      grant_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      grant_cnt_q    <= grant_cnt_d;
      timeout_flag_q <= timeout_flag_d;
      lost_flag_q    <= lost_flag_d;
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_d;
      busreq_n_q     <= busreq_n_d;
      grant_q        <= grant_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {26'b0, state_q, lost_flag_q, timeout_flag_q, grant_q};
      2'd1:    readdata[CNT_W-1:0] = grant_cnt_q;
      2'd2:    readdata = {30'b0, irq_en_q};
      default: readdata = '0;
    endcase
  end

  assign z80_busreq_n = busreq_n_q;
  assign bus_grant    = grant_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_z80_busreq_handshake.sv
// Directed and randomized check of z80_busreq_handshake against a cycle-level reference model.
module tb_z80_busreq_handshake;
  localparam int SYNC = 2;
  localparam int TO   = 8;
  localparam int CW   = 4;

  logic        clk = 1'b0;
  logic        reset, bus_req_n, z80_busack_n, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        z80_busreq_n, bus_grant, irq;

  int n_tests = 0;
  int n_fail  = 0;

  z80_busreq_handshake #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus_req_n(bus_req_n), .z80_busack_n(z80_busack_n),
    .z80_busreq_n(z80_busreq_n), .bus_grant(bus_grant), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: states 0..4 as in the register map, ack seen through a delay queue
  int  m_state, m_cnt, m_cyc, m_req_start;
  bit  m_to, m_lost, m_irq, m_breq_n, m_grant;
  bit  [1:0] m_en;
  bit  m_hist[$];

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_grant) | (32'(m_to) << 1) | (32'(m_lost) << 2) | (32'(m_state) << 3);
      2'd1:    return 32'(m_cnt);
      2'd2:    return 32'(m_en);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int nst;
    bit ack_s, set_to, set_lost, inc, wr;
    m_cyc++;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_to = 0; m_lost = 0; m_irq = 0; m_en = 0;
      m_breq_n = 1; m_grant = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(1'b1);
      return;
    end
    ack_s = m_hist[SYNC-1];
    nst = m_state; set_to = 0; set_lost = 0; inc = 0;
    case (m_state)
      0: if (!bus_req_n) nst = 1;
      1: if (!ack_s) begin nst = 2; inc = 1; end
         else if (bus_req_n) nst = 3;
         else if (m_cyc - m_req_start == TO) begin nst = 4; set_to = 1; end
      2: if (bus_req_n) nst = 3;
         else if (ack_s) begin nst = 1; set_lost = 1; end
      3: if (ack_s) nst = 0;
      default: if (bus_req_n && ack_s) nst = 0;
    endcase
    if (nst == 1 && m_state != 1) m_req_start = m_cyc;
    m_irq = (m_lost && m_en[1]) || (m_to && m_en[0]);
    wr = chipselect && !write_n;
    if (wr && address == 2'd3) begin
      if (writedata[1])  m_to   = 0;
      if (writedata[2])  m_lost = 0;
      if (writedata[31]) m_cnt  = 0;
    end
    if (wr && address == 2'd2) m_en = writedata[1:0];
    if (set_to)   m_to   = 1;
    if (set_lost) m_lost = 1;
    if (inc) m_cnt = (m_cnt + 1) % (1 << CW);
    m_hist.push_front(z80_busack_n);
    void'(m_hist.pop_back());
    m_state  = nst;
    m_breq_n = !(nst == 1 || nst == 2);
    m_grant  = (nst == 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("busreq_n", {31'b0, z80_busreq_n}, {31'b0, m_breq_n});
    chk("grant",    {31'b0, bus_grant},    {31'b0, m_grant});
    chk("irq",      {31'b0, irq},          {31'b0, m_irq});
    chk("readdata", readdata, m_read(address));
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk($sformatf("rd%0d", a), readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    m_cyc = 0; m_req_start = 0;
    reset = 1; bus_req_n = 1; z80_busack_n = 1; address = 0;
    chipselect = 0; write_n = 1; writedata = 0;
    tick(); tick();
    chk("rst_breq", {31'b0, z80_busreq_n}, 32'd1);
    chk("rst_grant", {31'b0, bus_grant}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rd(0, 0); rd(1, 0); rd(2, 0);
    reset = 0; tick();

    // normal grant
    bus_req_n = 0; tick();
    chk("req_lat", {31'b0, z80_busreq_n}, 32'd0);
    z80_busack_n = 0; tick(); tick();
    chk("grant_early", {31'b0, bus_grant}, 32'd0);
    tick();
    chk("grant_lat", {31'b0, bus_grant}, 32'd1);
    rd(1, 1); rd(0, 32'h11);

    // release, held ack keeps RELEASE
    bus_req_n = 1; tick();
    chk("rel_grant", {31'b0, bus_grant}, 32'd0);
    chk("rel_breq", {31'b0, z80_busreq_n}, 32'd1);
    rd(0, 32'h18); tick(); tick(); rd(0, 32'h18);
    z80_busack_n = 1; tick(); tick(); rd(0, 32'h18); tick(); rd(0, 0);

    // timeout with irq
    wr(2, 1); rd(2, 1);
    bus_req_n = 0; tick(); rd(0, 32'h08);
    repeat (7) tick();
    rd(0, 32'h08);
    tick(); rd(0, 32'h22);
    chk("to_breq", {31'b0, z80_busreq_n}, 32'd1);
    tick();
    chk("to_irq", {31'b0, irq}, 32'd1);
    bus_req_n = 1; wr(3, 2);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    tick();
    chk("irq_clr", {31'b0, irq}, 32'd0);
    rd(0, 0);

    // lost bus
    wr(3, 32'h8000_0000); rd(1, 0);
    bus_req_n = 0; tick();
    z80_busack_n = 0; repeat (3) tick();
    chk("lost_g1", {31'b0, bus_grant}, 32'd1);
    rd(1, 1);
    z80_busack_n = 1; repeat (2) tick();
    chk("lost_hold", {31'b0, bus_grant}, 32'd1);
    tick();
    chk("lost_drop", {31'b0, bus_grant}, 32'd0);
    chk("lost_breq", {31'b0, z80_busreq_n}, 32'd0);
    rd(0, 32'h0C);
    z80_busack_n = 0; repeat (3) tick();
    chk("lost_g2", {31'b0, bus_grant}, 32'd1);
    rd(1, 2); rd(0, 32'h15);
    bus_req_n = 1; tick();
    z80_busack_n = 1; repeat (3) tick();
    rd(0, 32'h04);
    wr(3, 4); rd(0, 0);

    // cancel on the cycle ack_s falls: ack wins
    bus_req_n = 0; tick();
    z80_busack_n = 0; tick(); tick();
    bus_req_n = 1; tick();
    chk("cancel_vs_ack", {31'b0, bus_grant}, 32'd1);
    tick();
    z80_busack_n = 1; repeat (3) tick();
    rd(0, 0);

    // clear write on the timeout cycle: set wins
    bus_req_n = 0; tick();
    repeat (7) tick();
    chipselect = 1; write_n = 0; address = 3; writedata = 2;
    tick();
    chipselect = 0; write_n = 1;
    rd(0, 32'h22);
    bus_req_n = 1; tick(); rd(0, 32'h02);

    // reset while granted
    wr(2, 3);
    bus_req_n = 0; tick();
    z80_busack_n = 0; repeat (3) tick();
    chk("pre_rst_grant", {31'b0, bus_grant}, 32'd1);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    reset = 1; tick();
    chk("mid_rst_grant", {31'b0, bus_grant}, 32'd0);
    chk("mid_rst_breq", {31'b0, z80_busreq_n}, 32'd1);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    rd(1, 0);
    reset = 0; bus_req_n = 1; z80_busack_n = 1; tick();

    // randomized traffic
    repeat (4000) begin
      if ($urandom_range(7) == 0) bus_req_n = ~bus_req_n;
      if ($urandom_range(5) == 0) z80_busack_n = ~z80_busack_n;
      address = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) begin
        chipselect = 1; write_n = 0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(1)); write_n = 1; writedata = $urandom;
      end
      reset = ($urandom_range(599) == 0);
      tick();
    end
    reset = 0; chipselect = 0; write_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
